// File: rtl/lzy_det_counter.sv
// lzy_det_counter: counts rising edges of the "100" detector output as a
// two-digit BCD value (00-99) with a sticky overflow flag, and drives a
// two-digit multiplexed seven-segment display.
//
// Build option: define LZY_DET_SAT_EN to saturate at 99 instead of wrapping
// to 00. Overflow is flagged in both builds.
//
// Digit-scan FSM:
//   state    | meaning
//   DIG_ONES | ones digit driven, dig = 2'b01
//   DIG_TENS | tens digit driven, dig = 2'b10
module lzy_det_counter #(
  parameter int SCAN_DIV = 1000,
  parameter int SCAN_W   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       det_in,
  input  logic       cnt_en,
  input  logic       clr,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       ovf,
  output logic [6:0] seg,
  output logic [1:0] dig
);

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } dig_state_t;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic              det_q;
  logic              hit;
  logic [3:0]        ones_q, ones_d;
  logic [3:0]        tens_q, tens_d;
  logic              ovf_q, ovf_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  dig_state_t        state_q, state_d;
  logic [1:0]        dig_q, dig_d;
  logic [6:0]        seg_q, seg_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // A level held high counts once; det_q resets low so a high input right
  // after reset is treated as a fresh edge.
  assign hit = det_in & ~det_q;

  // Input edge tracker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) det_q <= 1'b0;
    else      det_q <= det_in;
  end

  // BCD count update: clear beats a hit, digits stay within 0-9
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    ovf_d  = ovf_q;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
      ovf_d  = 1'b0;
    end else if (hit && cnt_en) begin
      if (ones_q < 4'd9) begin
        ones_d = ones_q + 4'd1;
      end else if (tens_q < 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ovf_d = 1'b1;
`ifdef LZY_DET_SAT_EN
        ones_d = 4'd9;
        tens_d = 4'd9;
`else
        ones_d = 4'd0;
        tens_d = 4'd0;
`endif
      end
    end
  end

  // Count and overflow registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      ovf_q  <= 1'b0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      ovf_q  <= ovf_d;
    end
  end

  // Scan timer and digit FSM next state; seg is decoded from the digit
  // registers as they stand now, giving one cycle of display latency.
  always_comb begin
    scan_d  = scan_q + 1'b1;
    state_d = state_q;
    if (scan_q == SCAN_LAST) begin
      scan_d  = '0;
      state_d = (state_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end
    dig_d = (state_d == DIG_TENS) ? 2'b10 : 2'b01;
    seg_d = seg_decode((state_d == DIG_TENS) ? tens_q : ones_q);
  end

  // Scan state and registered display outputs, updated on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q  <= '0;
      state_q <= DIG_ONES;
      dig_q   <= 2'b01;
      seg_q   <= 7'h3F;
    end else begin
      scan_q  <= scan_d;
      state_q <= state_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign dig  = dig_q;

endmodule

// File: tb/tb_lzy_det_counter.sv
// Directed bench for lzy_det_counter with a short scan period (SCAN_DIV=4).
module tb_lzy_det_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       det_in = 1'b0;
  logic       cnt_en = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] ones, tens;
  logic       ovf;
  logic [6:0] seg;
  logic [1:0] dig;

  int vectors = 0;
  int miscompares = 0;

  lzy_det_counter #(.SCAN_DIV(4), .SCAN_W(3)) dut (
    .clk(clk), .rst(rst), .det_in(det_in), .cnt_en(cnt_en), .clr(clr),
    .ones(ones), .tens(tens), .ovf(ovf), .seg(seg), .dig(dig)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    det_in = 1'b1;
    step();
    det_in = 1'b0;
    step();
    step();
  endtask

  task automatic check_count(input string tag, input logic [3:0] t, input logic [3:0] o, input logic v);
    check({tag, "_tens"}, {4'd0, tens}, {4'd0, t});
    check({tag, "_ones"}, {4'd0, ones}, {4'd0, o});
    check({tag, "_ovf"}, {7'd0, ovf}, {7'd0, v});
  endtask

  initial begin
    // reset state
    #12;
    check("rst_dig", {6'd0, dig}, 8'h01);
    check("rst_seg", {1'b0, seg}, 8'h3F);
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (10) step();
    check_count("idle", 4'd0, 4'd0, 1'b0);
    check("idle_seg", {1'b0, seg}, 8'h3F);

    // 12 pulses -> 12, then look at each digit on the display
    repeat (12) pulse();
    check_count("p12", 4'd1, 4'd2, 1'b0);
    for (int i = 0; i < 10 && dig !== 2'b01; i++) step();
    check("p12_dig_ones", {6'd0, dig}, 8'h01);
    check("p12_seg_ones", {1'b0, seg}, 8'h5B);
    for (int i = 0; i < 10 && dig !== 2'b10; i++) step();
    check("p12_dig_tens", {6'd0, dig}, 8'h02);
    check("p12_seg_tens", {1'b0, seg}, 8'h06);

    // long level counts once
    det_in = 1'b1;
    repeat (20) step();
    det_in = 1'b0;
    step();
    check_count("level", 4'd1, 4'd3, 1'b0);

    // disabled counting
    cnt_en = 1'b0;
    repeat (5) pulse();
    check_count("noen", 4'd1, 4'd3, 1'b0);
    cnt_en = 1'b1;

    // preload to 99, then overflow
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_count("clr0", 4'd0, 4'd0, 1'b0);
    repeat (99) pulse();
    check_count("p99", 4'd9, 4'd9, 1'b0);
    pulse();
`ifdef LZY_DET_SAT_EN
    check_count("ovf", 4'd9, 4'd9, 1'b1);
`else
    check_count("ovf", 4'd0, 4'd0, 1'b1);
`endif
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_count("clr_ovf", 4'd0, 4'd0, 1'b0);

    // clear beats a simultaneous hit at 37
    repeat (37) pulse();
    check_count("p37", 4'd3, 4'd7, 1'b0);
    det_in = 1'b1;
    clr = 1'b1;
    step();
    check_count("clr_hit", 4'd0, 4'd0, 1'b0);
    det_in = 1'b0;
    clr = 1'b0;
    step();
    check_count("clr_after", 4'd0, 4'd0, 1'b0);

    // 1,0,1 pattern gives two hits
    det_in = 1'b1; step();
    det_in = 1'b0; step();
    det_in = 1'b1; step();
    det_in = 1'b0; step();
    check_count("b2b", 4'd0, 4'd2, 1'b0);

    // async reset mid-scan at 45
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (45) pulse();
    check_count("p45", 4'd4, 4'd5, 1'b0);
    step();
    #2 rst = 1'b0;
    #1;
    check_count("arst", 4'd0, 4'd0, 1'b0);
    check("arst_dig", {6'd0, dig}, 8'h01);
    check("arst_seg", {1'b0, seg}, 8'h3F);

    // digit dwell of 4 cycles after reset release
    @(posedge clk);
    #3 rst = 1'b1;
    check("scan_k0", {6'd0, dig}, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("scan_k%0d", k), {6'd0, dig}, ((k / 4) % 2 == 1) ? 8'h02 : 8'h01);
    end

    // high input on the first cycle after reset counts
    rst = 1'b0;
    #2 det_in = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    step();
    check_count("first_hit", 4'd0, 4'd1, 1'b0);
    det_in = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
